// File: rtl/ram_port_arbiter_if.sv
// Bundle of requester, response, RAM-side and status signals for ram_port_arbiter.
// The arbiter connects through the slave modport; requesters/RAM model use master.
interface ram_port_arbiter_if #(
  parameter int DATA_W = 8,
  parameter int CMD_W  = DATA_W + 2
);
  logic              req0_valid;
  logic [CMD_W-1:0]  req0_data;
  logic              req0_ready;
  logic              rsp0_valid;
  logic [DATA_W-1:0] rsp0_data;

  logic              req1_valid;
  logic [CMD_W-1:0]  req1_data;
  logic              req1_ready;
  logic              rsp1_valid;
  logic [DATA_W-1:0] rsp1_data;

  logic [CMD_W-1:0]  ram_din;
  logic              ram_rx_valid;
  logic              ram_tx_valid;
  logic [DATA_W-1:0] ram_dout;

  logic              owner;
  logic              busy;
  logic              timeout_err;

  modport slave (
    input  req0_valid, req0_data, req1_valid, req1_data, ram_tx_valid, ram_dout,
    output req0_ready, rsp0_valid, rsp0_data, req1_ready, rsp1_valid, rsp1_data,
    output ram_din, ram_rx_valid, owner, busy, timeout_err
  );

  modport master (
    output req0_valid, req0_data, req1_valid, req1_data, ram_tx_valid, ram_dout,
    input  req0_ready, rsp0_valid, rsp0_data, req1_ready, rsp1_valid, rsp1_data,
    input  ram_din, ram_rx_valid, owner, busy, timeout_err
  );
endinterface

// File: rtl/ram_port_arbiter.sv
// Two-requester arbiter for a single-port command RAM. A grant is held for a whole
// address/data transaction so the RAM's internal address register is never shared mid-pair.
module ram_port_arbiter #(
  parameter int DATA_W  = 8,
  parameter int CMD_W   = DATA_W + 2,
  parameter int TIMEOUT = 16
) (
  input logic               clk,
  input logic               rst,
  ram_port_arbiter_if.slave bus
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  localparam logic [1:0] OP_WR_DATA = 2'b01;
  localparam logic [1:0] OP_RD_DATA = 2'b11;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOCK    = 2'd1,
    WAIT_RD = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_owner_q, last_owner_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [CMD_W-1:0]  ram_din_q, ram_din_d;
  logic              ram_rx_valid_q, ram_rx_valid_d;
  logic              rsp0_valid_q, rsp0_valid_d;
  logic [DATA_W-1:0] rsp0_data_q, rsp0_data_d;
  logic              rsp1_valid_q, rsp1_valid_d;
  logic [DATA_W-1:0] rsp1_data_q, rsp1_data_d;
  logic              timeout_err_q, timeout_err_d;

  logic              own_valid;
  logic [CMD_W-1:0]  own_word;
  logic [1:0]        own_op;
  logic              accept;
  logic              rd_done;
  logic              force_release;
  logic              grant;

  assign own_valid     = owner_q ? bus.req1_valid : bus.req0_valid;
  assign own_word      = owner_q ? bus.req1_data  : bus.req0_data;
  assign own_op        = own_word[CMD_W-1 -: 2];
  assign accept        = (state_q == LOCK) && own_valid;
  assign rd_done       = (state_q == WAIT_RD) && bus.ram_tx_valid;
  // An accepted word or a returned read beats an expiring counter on the same edge.
  assign force_release = (cnt_q == CNT_LAST) &&
                         (((state_q == LOCK) && !accept) || ((state_q == WAIT_RD) && !rd_done));
  // Prefer the requester that did not own the previous transaction.
  assign grant         = last_owner_q ? !bus.req0_valid : bus.req1_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      owner_q        <= 1'b0;
      last_owner_q   <= 1'b1;
      cnt_q          <= CNT_ZERO;
      ram_din_q      <= {CMD_W{1'b0}};
      ram_rx_valid_q <= 1'b0;
      rsp0_valid_q   <= 1'b0;
      rsp0_data_q    <= {DATA_W{1'b0}};
      rsp1_valid_q   <= 1'b0;
      rsp1_data_q    <= {DATA_W{1'b0}};
      timeout_err_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      owner_q        <= owner_d;
      last_owner_q   <= last_owner_d;
      cnt_q          <= cnt_d;
      ram_din_q      <= ram_din_d;
      ram_rx_valid_q <= ram_rx_valid_d;
      rsp0_valid_q   <= rsp0_valid_d;
      rsp0_data_q    <= rsp0_data_d;
      rsp1_valid_q   <= rsp1_valid_d;
      rsp1_data_q    <= rsp1_data_d;
      timeout_err_q  <= timeout_err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    cnt_d        = cnt_q;
    case (state_q)
      IDLE: begin
        cnt_d = CNT_ZERO;
        if (bus.req0_valid || bus.req1_valid) begin
          state_d = LOCK;
          owner_d = grant;
        end else begin
          state_d = IDLE;
        end
      end
      LOCK: begin
        if (accept) begin
          cnt_d = CNT_ZERO;
          case (own_op)
            OP_WR_DATA: begin
              state_d      = IDLE;
              last_owner_d = owner_q;
            end
            OP_RD_DATA: state_d = WAIT_RD;
            default:    state_d = LOCK;
          endcase
        end else if (force_release) begin
          state_d      = IDLE;
          last_owner_d = owner_q;
          cnt_d        = CNT_ZERO;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      WAIT_RD: begin
        if (rd_done || force_release) begin
          state_d      = IDLE;
          last_owner_d = owner_q;
          cnt_d        = CNT_ZERO;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  always_comb begin
    ram_din_d      = ram_din_q;
    ram_rx_valid_d = 1'b0;
    rsp0_valid_d   = 1'b0;
    rsp0_data_d    = rsp0_data_q;
    rsp1_valid_d   = 1'b0;
    rsp1_data_d    = rsp1_data_q;
    timeout_err_d  = force_release;
    if (accept) begin
      ram_din_d      = own_word;
      ram_rx_valid_d = 1'b1;
    end else begin
      ram_rx_valid_d = 1'b0;
    end
    if (rd_done && owner_q) begin
      rsp1_valid_d = 1'b1;
      rsp1_data_d  = bus.ram_dout;
    end else if (rd_done) begin
      rsp0_valid_d = 1'b1;
      rsp0_data_d  = bus.ram_dout;
    end else begin
      rsp0_valid_d = 1'b0;
      rsp1_valid_d = 1'b0;
    end
  end

  assign bus.req0_ready   = (state_q == LOCK) && !owner_q;
  assign bus.req1_ready   = (state_q == LOCK) && owner_q;
  assign bus.busy         = (state_q != IDLE);
  assign bus.owner        = owner_q;
  assign bus.ram_din      = ram_din_q;
  assign bus.ram_rx_valid = ram_rx_valid_q;
  assign bus.rsp0_valid   = rsp0_valid_q;
  assign bus.rsp0_data    = rsp0_data_q;
  assign bus.rsp1_valid   = rsp1_valid_q;
  assign bus.rsp1_data    = rsp1_data_q;
  assign bus.timeout_err  = timeout_err_q;

endmodule
